// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Shares one 2-stage fixed-point saturating multiplier among N requesters.
// A round-robin arbiter grants one valid requester per cycle. The accepted
// operand pair flows through two stages, and the product returns tagged
// with the requester index.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset; drops all in-flight ops
//   req_valid  per-lane request valid
//   req_ready  per-lane accept; at most one bit set
//   req_a/b    packed operands, lane i at [i*width +: width]
//   rsp_valid  result available
//   rsp_ready  consumer takes the result
//   rsp_id     requester index of the result
//   rsp_p      rounded (half-up) and saturated product
//   busy       any pipeline stage holds a valid entry
module mult_share_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned width    = 12,
    parameter int unsigned int_bits = 3,
    localparam int unsigned ID_W    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*width-1:0]   req_a,
    input  logic [N*width-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [width-1:0]     rsp_p,
    output logic                 busy
);

    localparam int unsigned Frac = width - int_bits - 1;
    // One extra bit so the rounding add can never overflow.
    localparam int unsigned PW   = 2 * width + 1;

    localparam logic signed [PW-1:0] RndK = PW'(1) << (Frac - 1);
    localparam logic signed [PW-1:0] PMax = (PW'(1) << (width - 1)) - PW'(1);
    localparam logic signed [PW-1:0] PMin = ~PMax;

    // State
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]  s1_id_q, s1_id_d;
    logic [width-1:0] s1_a_q, s1_a_d;
    logic [width-1:0] s1_b_q, s1_b_d;
    logic             s2_valid_q, s2_valid_d;
    logic [ID_W-1:0]  s2_id_q, s2_id_d;
    logic [width-1:0] s2_p_q, s2_p_d;

    // Arbitration
    logic             adv;
    logic             grant_any;
    logic [ID_W-1:0]  grant_id;
    logic [N-1:0]     grant;
    logic [ID_W-1:0]  cand;
    int unsigned      cand_sum;
    logic             accept;
    logic [width-1:0] a_sel, b_sel;

    // Arithmetic
    logic signed [2*width-1:0] a_ext, b_ext, prod;
    logic signed [PW-1:0]      rnd, shifted;
    logic [width-1:0]          prod_sat;

    // The whole pipeline moves only when the output slot is free or drains.
    assign adv = !s2_valid_q || rsp_ready;

    // Round-robin search starting at ptr_q, wrapping N-1 -> 0.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        cand_sum  = 0;
        for (int unsigned off = 0; off < N; off++) begin
            cand_sum = 32'(ptr_q) + off;
            if (cand_sum >= N) begin
                cand_sum = cand_sum - N;
            end
            cand = ID_W'(cand_sum);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
        grant = grant_any ? (N'(1) << grant_id) : '0;
    end

    assign accept    = adv && grant_any;
    assign req_ready = adv ? grant : '0;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                a_sel = req_a[i*width +: width];
                b_sel = req_b[i*width +: width];
            end
        end
    end

    // Stage-2 arithmetic: full-precision product, round half-up, saturate.
    always_comb begin
        a_ext   = {{width{s1_a_q[width-1]}}, s1_a_q};
        b_ext   = {{width{s1_b_q[width-1]}}, s1_b_q};
        prod    = a_ext * b_ext;
        rnd     = {prod[2*width-1], prod} + RndK;
        shifted = rnd >>> Frac;
        if (shifted > PMax) begin
            prod_sat = PMax[width-1:0];
        end else if (shifted < PMin) begin
            prod_sat = PMin[width-1:0];
        end else begin
            prod_sat = shifted[width-1:0];
        end
    end

    // Next-state
    always_comb begin
        ptr_d      = ptr_q;
        s1_valid_d = s1_valid_q;
        s1_id_d    = s1_id_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        s2_id_d    = s2_id_q;
        s2_p_d     = s2_p_q;

        if (adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_id_d = grant_id;
                s1_a_d  = a_sel;
                s1_b_d  = b_sel;
                ptr_d   = (grant_id == ID_W'(N - 1)) ? '0 : grant_id + ID_W'(1);
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_id_d = s1_id_q;
                s2_p_d  = prod_sat;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_p_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            s2_id_q    <= s2_id_d;
            s2_p_q     <= s2_p_d;
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_id    = s2_id_q;
    assign rsp_p     = s2_p_q;
    assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomised and directed bench for mult_share_arbiter (N=4, width=12, int_bits=3).
// A scoreboard queue models the multiplier: each accepted op is aged from 1 to 2
// as the pipeline advances, and is visible as a response once it reaches age 2.
module tb_mult_share_arbiter;

    localparam int N    = 4;
    localparam int W    = 12;
    localparam int FRAC = 8;
    localparam int ID_W = 2;

    logic            clk;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [ID_W-1:0] rsp_id;
    logic [W-1:0]    rsp_p;
    logic            busy;

    mult_share_arbiter #(
        .N        (N),
        .width    (W),
        .int_bits (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus state
    logic [N-1:0] va;
    logic [W-1:0] aa [N];
    logic [W-1:0] bb [N];

    assign req_valid = va;
    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = aa[i];
            req_b[i*W +: W] = bb[i];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference arithmetic: floor((a*b + 2^(FRAC-1)) / 2^FRAC), clamped to W bits.
    function automatic logic [W-1:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b);
        int sa, sb, t, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        t  = sa * sb + (1 << (FRAC - 1));
        if (t >= 0) r = t / (1 << FRAC);
        else        r = -((-t + (1 << FRAC) - 1) / (1 << FRAC));
        if (r > 2047)       r = 2047;
        else if (r < -2048) r = -2048;
        return W'(r);
    endfunction

    // Scoreboard model
    typedef struct {
        int         id;
        logic [W-1:0] p;
        int         age;
    } ent_t;

    ent_t         q[$];
    int           acc_log[$];
    int           m_ptr = 0;
    bit           m_adv = 1'b0;
    bit           m_pop = 1'b0;
    int           m_gid = -1;
    logic [N-1:0] m_grant;
    logic [N-1:0] acc_vec = '0;
    bit           mon_en = 1'b0;

    always @(negedge clk) begin
        bit exp_rv;
        m_gid   = -1;
        m_adv   = 1'b0;
        m_pop   = 1'b0;
        m_grant = '0;
        if (reset_n && mon_en) begin
            exp_rv = (q.size() > 0) && (q[0].age == 2);
            check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            check_eq("busy", 32'(busy), 32'(q.size() > 0));
            if (exp_rv) begin
                check_eq("rsp_id", 32'(rsp_id), 32'(q[0].id));
                check_eq("rsp_p", 32'(rsp_p), 32'(q[0].p));
            end
            m_adv = !exp_rv || rsp_ready;
            if (m_adv) begin
                for (int off = 0; off < N; off++) begin
                    int idx;
                    idx = (m_ptr + off) % N;
                    if (m_gid < 0 && req_valid[idx]) begin
                        m_gid        = idx;
                        m_grant[idx] = 1'b1;
                    end
                end
            end
            check_eq("req_ready", 32'(req_ready), 32'(m_grant));
            m_pop = exp_rv && rsp_ready;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_ptr   = 0;
            acc_vec = '0;
        end else if (mon_en) begin
            ent_t e;
            if (m_pop) void'(q.pop_front());
            if (m_adv) begin
                foreach (q[i]) if (q[i].age < 2) q[i].age++;
            end
            acc_vec = m_grant;
            if (m_gid >= 0) begin
                e.id  = m_gid;
                e.p   = ref_mult(aa[m_gid], bb[m_gid]);
                e.age = 1;
                q.push_back(e);
                acc_log.push_back(m_gid);
                m_ptr = (m_gid + 1) % N;
            end
        end
    end

    // Stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 12'h7ff;
            1:       return 12'h800;
            2:       return 12'hfff;
            3:       return 12'h001;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic new_data(input int i);
        aa[i] = rnd_op();
        bb[i] = rnd_op();
    endtask

    // New operands for lanes accepted at the last edge; keep=1 keeps them requesting.
    task automatic refresh(input bit keep);
        for (int i = 0; i < N; i++) begin
            if (acc_vec[i]) begin
                new_data(i);
                va[i] = keep ? 1'b1 : ($urandom_range(0, 1) == 1);
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Arithmetic vectors
    logic [W-1:0] t1_a [8] = '{12'h001, 12'hfff, 12'h7ff, 12'h800, 12'h800, 12'h001, 12'h080, 12'hf80};
    logic [W-1:0] t1_b [8] = '{12'habc, 12'habc, 12'h7ff, 12'h800, 12'h7ff, 12'hfff, 12'h101, 12'h0ff};
    logic [W-1:0] t1_p [8] = '{12'hffb, 12'h005, 12'h7ff, 12'h7ff, 12'h800, 12'h000, 12'h081, 12'hf81};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base, s0, idx, slots, exp_ptr;
        bit found, b2b;

        va        = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            aa[i] = '0;
            bb[i] = '0;
        end
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
        check_eq("rst_rsp_p", 32'(rsp_p), 32'd0);
        mon_en = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;

        // 1. Arithmetic on lane 0, response in the second cycle after the accept cycle.
        for (int k = 0; k < 8; k++) begin
            va    = 4'b0001;
            aa[0] = t1_a[k];
            bb[0] = t1_b[k];
            tick();
            va = '0;
            check_eq("t1_early", 32'(rsp_valid), 32'd0);
            tick();
            check_eq("t1_valid", 32'(rsp_valid), 32'd1);
            check_eq("t1_p", 32'(rsp_p), 32'(t1_p[k]));
            check_eq("t1_id", 32'(rsp_id), 32'd0);
            tick();
        end

        // 2. Round robin with all lanes requesting from reset.
        va = '1;
        for (int i = 0; i < N; i++) new_data(i);
        base = acc_log.size();
        do_reset();
        for (int k = 0; k < 12; k++) begin
            tick();
            refresh(1'b1);
        end
        check_eq("rr_count", 32'(acc_log.size() - base >= 8), 32'd1);
        for (int k = 0; k < 8; k++) begin
            if (base + k < acc_log.size())
                check_eq("rr_order", 32'(acc_log[base + k]), 32'(k % N));
        end

        // 3. Fairness: lane 1 continuous, lane 3 raised later.
        va = '0;
        do_reset();
        va[1] = 1'b1;
        new_data(1);
        s0 = acc_log.size();
        for (int c = 0; c < 30; c++) begin
            if (c == 5) begin
                va[3] = 1'b1;
                new_data(3);
                s0 = acc_log.size();
            end
            tick();
            refresh(1'b1);
        end
        found = 1'b0;
        idx   = 0;
        for (int j = s0; j < acc_log.size(); j++) begin
            if (!found && acc_log[j] == 3) begin
                found = 1'b1;
                idx   = j;
            end
        end
        check_eq("fair_found", 32'(found), 32'd1);
        slots = idx - s0 + 1;
        check_eq("fair_slots", 32'(found && slots <= 2), 32'd1);
        b2b = 1'b0;
        for (int j = s0 + 1; j <= idx; j++) begin
            if (acc_log[j] == 1 && acc_log[j-1] == 1) b2b = 1'b1;
        end
        check_eq("fair_b2b", 32'(b2b), 32'd0);

        // 4. Backpressure with a full pipeline.
        va = '1;
        for (int i = 0; i < N; i++) new_data(i);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            refresh(1'b1);
        end
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            refresh(1'b1);
            check_eq("bp_ready", 32'(req_ready), 32'd0);
            check_eq("bp_hold_valid", 32'(rsp_valid), 32'd1);
        end
        rsp_ready = 1'b1;
        va        = '0;
        for (int k = 0; k < 6; k++) tick();
        check_eq("bp_busy", 32'(busy), 32'd0);

        // 6. Idle: pointer must survive 10 quiet cycles.
        exp_ptr = (acc_log[acc_log.size() - 1] + 1) % N;
        for (int k = 0; k < 10; k++) tick();
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        va = '1;
        for (int i = 0; i < N; i++) new_data(i);
        base = acc_log.size();
        tick();
        check_eq("idle_acc", 32'(acc_log.size() > base), 32'd1);
        if (acc_log.size() > base) check_eq("idle_ptr", 32'(acc_log[base]), 32'(exp_ptr));
        refresh(1'b1);

        // 5. Asynchronous reset with both stages full.
        for (int k = 0; k < 3; k++) begin
            tick();
            refresh(1'b1);
        end
        #2 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        base    = acc_log.size();
        tick();
        refresh(1'b1);
        check_eq("mid_rst_acc", 32'(acc_log.size() > base), 32'd1);
        if (acc_log.size() > base) check_eq("mid_rst_first", 32'(acc_log[base]), 32'd0);

        // Random traffic with random backpressure and occasional withdrawn requests.
        for (int c = 0; c < 400; c++) begin
            rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
            refresh(1'b0);
            for (int i = 0; i < N; i++) begin
                if (!acc_vec[i]) begin
                    if (!va[i] && $urandom_range(0, 9) < 4) begin
                        va[i] = 1'b1;
                        new_data(i);
                    end else if (va[i] && $urandom_range(0, 99) < 3) begin
                        va[i] = 1'b0;
                    end
                end
            end
        end

        va        = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check_eq("final_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
